// File: rtl/lif_epoch_scheduler.sv
// Time-multiplexed leaky-integrate-and-fire controller: one shared update datapath
// walks N_NEURONS virtual neurons once per epoch, opened every TICK_DIV cycles.
module lif_epoch_scheduler #(
  parameter int N_NEURONS  = 4,
  parameter int V_W        = 8,
  parameter int LEAK_SHIFT = 3,
  parameter int TICK_DIV   = 8,
  parameter int REFRAC     = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [N_NEURONS-1:0]         spike_in,
  input  logic [V_W-1:0]               threshold,
  input  logic [V_W-1:0]               weight,
  input  logic [$clog2(N_NEURONS)-1:0] dbg_idx,
  output logic [N_NEURONS-1:0]         spike_out,
  output logic                         epoch_done,
  output logic                         busy,
  output logic [V_W-1:0]               dbg_v
);

  localparam int IDX_W = $clog2(N_NEURONS);
  localparam int CNT_W = $clog2(TICK_DIV);
  localparam int R_W   = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     tick_cnt;
  logic                 epoch_req;
  logic [IDX_W-1:0]     idx;
  logic                 last_idx;
  logic [N_NEURONS-1:0] pending;
  logic [N_NEURONS-1:0] fire;
  logic [N_NEURONS-1:0] clr_mask;
  logic [V_W-1:0]       v      [N_NEURONS];
  logic [R_W-1:0]       refrac [N_NEURONS];

  logic [V_W-1:0]       cur_v, leaked, sum_sat;
  logic [V_W:0]         sum;
  logic [R_W-1:0]       cur_ref;
  logic                 cur_in, cur_fire;

  assign epoch_req = en && (tick_cnt == CNT_W'(TICK_DIV - 1));
  assign last_idx  = (idx == IDX_W'(N_NEURONS - 1));

  always_ff @(posedge clk) begin
    if (rst)
      tick_cnt <= '0;
    else if (en)
      tick_cnt <= epoch_req ? '0 : tick_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    busy       = 1'b0;
    epoch_done = 1'b0;
    spike_out  = '0;
    case (state)
      IDLE: if (epoch_req) state_nxt = SCAN;
      SCAN: begin
        busy = 1'b1;
        if (last_idx) state_nxt = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        epoch_done = 1'b1;
        spike_out  = fire;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shared datapath for the neuron selected by idx; saturates in V_W+1 bits.
  always_comb begin
    cur_v    = v[idx];
    cur_ref  = refrac[idx];
    cur_in   = pending[idx] | spike_in[idx];
    leaked   = cur_v - (cur_v >> LEAK_SHIFT);
    sum      = {1'b0, leaked} + (cur_in ? {1'b0, weight} : '0);
    sum_sat  = sum[V_W] ? '1 : sum[V_W-1:0];
    cur_fire = (cur_ref == '0) && (sum_sat >= threshold);
    clr_mask = (state == SCAN) ? (N_NEURONS'(1) << idx) : '0;
  end

  // A spike arriving on the scanned neuron's own cycle is consumed, not re-latched.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      fire    <= '0;
      idx     <= '0;
      for (int i = 0; i < N_NEURONS; i++) begin
        v[i]      <= '0;
        refrac[i] <= '0;
      end
    end else begin
      pending <= (pending | spike_in) & ~clr_mask;
      case (state)
        IDLE: begin
          if (epoch_req) begin
            idx  <= '0;
            fire <= '0;
          end
        end
        SCAN: begin
          idx <= last_idx ? '0 : idx + 1'b1;
          if (cur_ref != '0) begin
            refrac[idx] <= cur_ref - 1'b1;
            v[idx]      <= '0;
          end else if (cur_fire) begin
            fire[idx]   <= 1'b1;
            v[idx]      <= '0;
            refrac[idx] <= R_W'(REFRAC);
          end else begin
            v[idx] <= sum_sat;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    dbg_v = '0;
    if ({1'b0, dbg_idx} < (IDX_W + 1)'(N_NEURONS))
      dbg_v = v[dbg_idx];
  end

endmodule

// File: tb/tb_lif_epoch_scheduler.sv
// Bench for lif_epoch_scheduler: directed epoch tables plus randomized traffic
// compared every cycle against an arithmetic reference model.
`timescale 1ns/100ps
module tb_lif_epoch_scheduler;

  localparam int N  = 4;
  localparam int VW = 8;
  localparam int LS = 3;
  localparam int TD = 8;
  localparam int RF = 2;

  logic          clk = 1'b0;
  logic          rst, en;
  logic [N-1:0]  spike_in;
  logic [VW-1:0] threshold, weight;
  logic [1:0]    dbg_idx;
  logic [N-1:0]  spike_out;
  logic          epoch_done, busy;
  logic [VW-1:0] dbg_v;

  always #10 clk = ~clk;

  lif_epoch_scheduler #(.N_NEURONS(N), .V_W(VW), .LEAK_SHIFT(LS), .TICK_DIV(TD), .REFRAC(RF)) dut (
    .clk(clk), .rst(rst), .en(en), .spike_in(spike_in), .threshold(threshold),
    .weight(weight), .dbg_idx(dbg_idx), .spike_out(spike_out),
    .epoch_done(epoch_done), .busy(busy), .dbg_v(dbg_v)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: m_age counts cycles since the epoch started (0 = not in an epoch).
  int           m_tick, m_age;
  int           m_v   [N];
  int           m_ref [N];
  bit           m_pend[N];
  logic [N-1:0] m_fire;
  logic [VW-1:0] seen_v[N];

  typedef struct {
    logic [N-1:0]  spk;
    logic [VW-1:0] thr;
    logic [VW-1:0] wt;
    logic [1:0]    sel;
    logic [N-1:0]  exp_out;
    int            exp_v;
  } vec_t;
  vec_t tbl[8];

  function automatic void model_reset();
    m_tick = 0;
    m_age  = 0;
    m_fire = '0;
    for (int k = 0; k < N; k++) begin
      m_v[k] = 0; m_ref[k] = 0; m_pend[k] = 1'b0;
    end
  endfunction

  function automatic void model_step();
    bit req, inp;
    int i, leaked, sum;
    if (rst) begin
      model_reset();
      return;
    end
    req = en && (m_tick == TD - 1);
    if (en) m_tick = (m_tick == TD - 1) ? 0 : m_tick + 1;
    if (m_age >= 1 && m_age <= N) begin
      i   = m_age - 1;
      inp = m_pend[i] || spike_in[i];
      if (m_ref[i] > 0) begin
        m_ref[i] = m_ref[i] - 1;
        m_v[i]   = 0;
      end else begin
        leaked = m_v[i] - m_v[i] / (1 << LS);
        sum    = leaked + (inp ? int'(weight) : 0);
        if (sum > (1 << VW) - 1) sum = (1 << VW) - 1;
        if (sum >= int'(threshold)) begin
          m_fire[i] = 1'b1; m_v[i] = 0; m_ref[i] = RF;
        end else begin
          m_v[i] = sum;
        end
      end
      for (int k = 0; k < N; k++) m_pend[k] = (k == i) ? 1'b0 : (m_pend[k] | spike_in[k]);
    end else begin
      for (int k = 0; k < N; k++) m_pend[k] = m_pend[k] | spike_in[k];
    end
    if (m_age == 0) begin
      if (req) begin m_age = 1; m_fire = '0; end
    end else if (m_age == N + 1) begin
      m_age = 0;
    end else begin
      m_age = m_age + 1;
    end
  endfunction

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic checkOutput();
    checkValue("busy", busy, (m_age != 0));
    checkValue("epoch_done", epoch_done, (m_age == N + 1));
    checkValue("spike_out", spike_out, (m_age == N + 1) ? m_fire : '0);
    for (int d = 0; d < N; d++) begin
      dbg_idx = 2'(d);
      #1;
      seen_v[d] = dbg_v;
      checkValue($sformatf("dbg_v[%0d]", d), dbg_v, m_v[d]);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic [N-1:0] s);
    rst = r; en = e; spike_in = s;
    model_step();
    @(posedge clk);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic run_epoch(input logic [N-1:0] s, output logic [N-1:0] so, output bit found);
    found = 1'b0;
    so    = '0;
    for (int k = 0; k < 3 * TD && !found; k++) begin
      applyStimulus(1'b0, 1'b1, s);
      if (epoch_done === 1'b1) begin
        found = 1'b1;
        so    = spike_out;
      end
    end
    if (!found) checkValue("epoch_timeout", 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [N-1:0] so;
    bit found;
    int first_scan, done1, done2;
    logic [VW-1:0] thr_r, wt_r;
    int v1_exp[10];

    tbl[0] = '{4'b0001, 8'd40,  8'd16,  2'd0, 4'b0000, 16};
    tbl[1] = '{4'b0001, 8'd40,  8'd16,  2'd0, 4'b0000, 30};
    tbl[2] = '{4'b0001, 8'd40,  8'd16,  2'd0, 4'b0001, 0};
    tbl[3] = '{4'b0001, 8'd40,  8'd16,  2'd0, 4'b0000, 0};
    tbl[4] = '{4'b0001, 8'd40,  8'd16,  2'd0, 4'b0000, 0};
    tbl[5] = '{4'b0001, 8'd40,  8'd16,  2'd0, 4'b0000, 16};
    tbl[6] = '{4'b0100, 8'd255, 8'd200, 2'd2, 4'b0000, 200};
    tbl[7] = '{4'b0100, 8'd255, 8'd200, 2'd2, 4'b0100, 0};
    v1_exp = '{16, 14, 13, 12, 11, 10, 9, 8, 7, 7};

    threshold = 8'd40; weight = 8'd16; dbg_idx = '0;
    rst = 1'b1; en = 1'b1; spike_in = '0;
    model_reset();
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, '0);
    applyStimulus(1'b1, 1'b1, '0);
    checkValue("reset_busy", busy, 0);
    checkValue("reset_spike_out", spike_out, 0);
    for (int d = 0; d < N; d++) checkValue("reset_dbg_v", seen_v[d], 0);

    // Epoch cadence from reset release with no input.
    first_scan = 0; done1 = 0; done2 = 0;
    for (int c = 1; c <= 30; c++) begin
      applyStimulus(1'b0, 1'b1, '0);
      if (busy === 1'b1 && first_scan == 0) first_scan = c;
      if (epoch_done === 1'b1) begin
        if (done1 == 0) done1 = c;
        else if (done2 == 0) done2 = c;
      end
    end
    checkValue("first_scan_edge", first_scan, 8);
    checkValue("first_done_edge", done1, 12);
    checkValue("done_period", done2 - done1, 8);

    // Held input to neuron 0 (fire, then refractory), then saturation on neuron 2.
    for (int t = 0; t < 8; t++) begin
      threshold = tbl[t].thr;
      weight    = tbl[t].wt;
      run_epoch(tbl[t].spk, so, found);
      checkValue($sformatf("tbl%0d_spike_out", t), so, tbl[t].exp_out);
      checkValue($sformatf("tbl%0d_v", t), seen_v[tbl[t].sel], tbl[t].exp_v);
    end

    // Single-cycle pulse on neuron 1 decays to the leak floor and never fires.
    threshold = 8'd40; weight = 8'd16;
    applyStimulus(1'b0, 1'b1, 4'b0010);
    for (int t = 0; t < 10; t++) begin
      run_epoch('0, so, found);
      checkValue($sformatf("pulse_v1_e%0d", t), seen_v[1], v1_exp[t]);
      checkValue($sformatf("pulse_fire1_e%0d", t), so[1], 0);
    end

    // Reset while SCAN is on neuron 2 drops the epoch and all latched spikes.
    run_epoch('0, so, found);
    applyStimulus(1'b0, 1'b1, 4'b1111);
    found = 1'b0;
    for (int k = 0; k < 3 * TD && !found; k++) begin
      applyStimulus(1'b0, 1'b1, '0);
      if (busy === 1'b1) found = 1'b1;
    end
    checkValue("s6_scan_seen", found, 1);
    applyStimulus(1'b0, 1'b1, '0);
    applyStimulus(1'b0, 1'b1, '0);
    checkValue("s6_busy_idx2", busy, 1);
    applyStimulus(1'b1, 1'b1, '0);
    checkValue("s6_busy_after_rst", busy, 0);
    checkValue("s6_done_after_rst", epoch_done, 0);
    checkValue("s6_spike_after_rst", spike_out, 0);
    for (int d = 0; d < N; d++) checkValue("s6_dbg_v_after_rst", seen_v[d], 0);
    run_epoch('0, so, found);
    checkValue("s6_next_epoch_fire", so, 0);
    for (int d = 0; d < N; d++) checkValue("s6_pending_lost", seen_v[d], 0);

    // Randomized traffic including en freezes, resets and threshold 0.
    for (int c = 0; c < 2000; c++) begin
      logic [N-1:0] s;
      if ($urandom_range(0, 49) == 0) begin
        thr_r = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
        wt_r  = 8'($urandom_range(0, 255));
        threshold = thr_r;
        weight    = wt_r;
      end
      for (int k = 0; k < N; k++) s[k] = ($urandom_range(0, 3) == 0);
      applyStimulus(($urandom_range(0, 299) == 0), ($urandom_range(0, 7) != 0), s);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
